// File: rtl/uart_tx_if.sv
// uart_tx_if: register-block side of the uart transmitter (data write, status, irq)
interface uart_tx_if;
  logic [7:0]  tx_d;
  logic        tx_d_valid;
  logic        tx_status_clr;
  logic [31:0] tx_status;
  logic        irq;
  modport master (output tx_d, tx_d_valid, tx_status_clr, input tx_status, irq);
  modport slave  (input tx_d, tx_d_valid, tx_status_clr, output tx_status, irq);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: fifo-buffered 8-bit uart transmitter with optional parity, 1/2 stop bits, status and irq
module uart_tx #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] divider_i,
  input  logic [5:0]  config_i,
  input  logic [31:0] irqmask_i,
  output logic        tx_o,
  uart_tx_if.slave    bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t        state_q, state_d;
  logic [31:0]   bcnt_q, bcnt_d, div_q, div_d;
  logic [7:0]    sh_q, sh_d, head;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d, par_en_q, par_en_d, stop2_q, stop2_d, par_q, par_d;
  logic          line_q, line_d, ovf_q, ovf_d, done_q, done_d, irq_q, irq_d;
  logic [CW-1:0] lvl_q, lvl_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          full, empty, busy, tick, push, pop, last_stop;
  logic [4:0]    lvl5;
  logic          unused_bits;
  assign unused_bits = ^{config_i[5:4], irqmask_i[31:2]};
  always_comb begin
    full = lvl_q == CW'(FIFO_DEPTH);
    empty = lvl_q == '0;
    busy = state_q != IDLE;
    tick = bcnt_q == div_q - 32'd1;
    push = bus.tx_d_valid & ~full;
    last_stop = state_q == STOP & tick & (~stop2_q | stop_q);
    pop = config_i[0] & ~empty & (state_q == IDLE | last_stop);
    head = mem_q[rd_q];
    state_d = state_q;
    bcnt_d = busy & ~tick ? bcnt_q + 32'd1 : '0;
    div_d = div_q;
    sh_d = sh_q;
    bit_d = bit_q;
    stop_d = stop_q;
    par_en_d = par_en_q;
    stop2_d = stop2_q;
    par_d = par_q;
    case (state_q)
      START:  if (tick) state_d = DATA;
      DATA:   if (tick) begin
        sh_d = sh_q >> 1;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: if (tick) state_d = STOP;
      STOP:   if (tick) begin
        stop_d = 1'b1;
        if (last_stop) state_d = IDLE;
      end
      default: ;
    endcase
    if (pop) begin
      state_d = START;
      bcnt_d = '0;
      sh_d = head;
      bit_d = '0;
      stop_d = 1'b0;
      div_d = divider_i == '0 ? 32'd1 : divider_i;
      par_en_d = config_i[1];
      par_d = ^head ^ config_i[2];
      stop2_d = config_i[3];
    end
    line_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : state_d == PARITY ? par_d : 1'b1;
    lvl_d = lvl_q + CW'(push) - CW'(pop);
    rd_d = rd_q + AW'(pop);
    wr_d = wr_q + AW'(push);
    ovf_d = (bus.tx_d_valid & full) | (ovf_q & ~bus.tx_status_clr);
    done_d = last_stop | (done_q & ~bus.tx_status_clr);
    irq_d = |({done_q, empty & ~busy} & irqmask_i[1:0]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q <= '0;
      div_q <= 32'd1;
      sh_q <= '0;
      bit_q <= '0;
      stop_q <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q <= 1'b0;
      par_q <= 1'b0;
      line_q <= 1'b1;
      lvl_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q <= bcnt_d;
      div_q <= div_d;
      sh_q <= sh_d;
      bit_q <= bit_d;
      stop_q <= stop_d;
      par_en_q <= par_en_d;
      stop2_q <= stop2_d;
      par_q <= par_d;
      line_q <= line_d;
      lvl_q <= lvl_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
      irq_q <= irq_d;
    end
    if (push) mem_q[wr_q] <= bus.tx_d;
  end
  assign lvl5 = 5'(lvl_q);
  assign tx_o = line_q;
  assign bus.irq = irq_q;
  assign bus.tx_status = {19'd0, lvl5, 3'd0, done_q, ovf_q, busy, full, empty};
endmodule
